// File: rtl/clock_pkg.sv
// Shared types and constants for the clock_alarm time-of-day core.
package clock_pkg;

   typedef enum logic [2:0] {
      MODE_RUN       = 3'd0,
      MODE_SET_SEC   = 3'd1,
      MODE_SET_MIN   = 3'd2,
      MODE_SET_HOUR  = 3'd3,
      MODE_SET_AMIN  = 3'd4,
      MODE_SET_AHOUR = 3'd5
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      RINGING,
      SNOOZED
   } alarm_state_t;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;
   localparam int FIELD_W  = 6;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int width_of(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with single-step up/down edits, a tick increment and carry out.
module wrap_counter #(
   parameter int MAX     = 59,
   parameter int WIDTH   = 6,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             inc,
   input  logic             up,
   input  logic             dn,
   output logic [WIDTH-1:0] cnt,
   output logic             carry
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST = WIDTH'(RST_VAL);

   logic at_top;

   assign at_top = (cnt == TOP);
   assign carry  = inc & at_top;

   // Any edit pulse claims the field for this cycle, so a simultaneous tick is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= RST;
      end else if (clear) begin
         cnt <= '0;
      end else if (up && !dn) begin
         cnt <= at_top ? '0 : cnt + 1'b1;
      end else if (dn && !up) begin
         cnt <= (cnt == '0) ? TOP : cnt - 1'b1;
      end else if (inc && !(up || dn)) begin
         cnt <= at_top ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/clock_alarm.sv
// 24-hour clock with one alarm, ring timeout and snooze.
// Define TWELVE_HOUR_EN to add the disp_hours/pm 12-hour display outputs.
module clock_alarm
   import clock_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_MIN  = 5,
   parameter int ALARM_RST_H = 7,
   parameter int ALARM_RST_M = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic               plus,
   input  logic               minus,
   input  logic [2:0]         mode,
   input  logic               alarm_en,
   input  logic               snooze,
   input  logic               stop,
   output logic [FIELD_W-1:0] hours,
   output logic [FIELD_W-1:0] mins,
   output logic [FIELD_W-1:0] secs,
   output logic [FIELD_W-1:0] alarm_hours,
   output logic [FIELD_W-1:0] alarm_mins,
   output logic               ringing,
   output logic               tick_1hz
`ifdef TWELVE_HOUR_EN
   ,
   output logic [FIELD_W-1:0] disp_hours,
   output logic               pm
`endif
);

   localparam int DIV_W  = width_of(CLK_HZ - 1);
   localparam int RING_W = width_of(RING_SECS);
   localparam int SNZ_W  = $clog2(SNOOZE_MIN * 60 + 1);

   localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
   localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * 60);

   logic set_sec, set_min, set_hour, set_amin, set_ahour;
   logic advance, div_clear;
   logic sec_carry, min_carry, hour_carry;
   logic [1:0] unused_alarm_carry;
   logic [DIV_W-1:0] divider;

   assign set_sec   = (mode == MODE_SET_SEC);
   assign set_min   = (mode == MODE_SET_MIN);
   assign set_hour  = (mode == MODE_SET_HOUR);
   assign set_amin  = (mode == MODE_SET_AMIN);
   assign set_ahour = (mode == MODE_SET_AHOUR);

   assign div_clear = set_sec & (plus | minus);
   assign advance   = tick_1hz & run & ~(set_sec | set_min | set_hour);

   wrap_counter #(.MAX(CLK_HZ - 1), .WIDTH(DIV_W), .RST_VAL(0)) u_div (
      .clk(clk), .reset_n(reset_n), .clear(div_clear), .inc(1'b1),
      .up(1'b0), .dn(1'b0), .cnt(divider), .carry(tick_1hz)
   );

   wrap_counter #(.MAX(SEC_MAX), .WIDTH(FIELD_W), .RST_VAL(0)) u_sec (
      .clk(clk), .reset_n(reset_n), .clear(1'b0), .inc(advance),
      .up(plus & set_sec), .dn(minus & set_sec), .cnt(secs), .carry(sec_carry)
   );

   wrap_counter #(.MAX(MIN_MAX), .WIDTH(FIELD_W), .RST_VAL(0)) u_min (
      .clk(clk), .reset_n(reset_n), .clear(1'b0), .inc(sec_carry),
      .up(plus & set_min), .dn(minus & set_min), .cnt(mins), .carry(min_carry)
   );

   wrap_counter #(.MAX(HOUR_MAX), .WIDTH(FIELD_W), .RST_VAL(0)) u_hour (
      .clk(clk), .reset_n(reset_n), .clear(1'b0), .inc(min_carry),
      .up(plus & set_hour), .dn(minus & set_hour), .cnt(hours), .carry(hour_carry)
   );

   wrap_counter #(.MAX(MIN_MAX), .WIDTH(FIELD_W), .RST_VAL(ALARM_RST_M)) u_amin (
      .clk(clk), .reset_n(reset_n), .clear(1'b0), .inc(1'b0),
      .up(plus & set_amin), .dn(minus & set_amin), .cnt(alarm_mins),
      .carry(unused_alarm_carry[0])
   );

   wrap_counter #(.MAX(HOUR_MAX), .WIDTH(FIELD_W), .RST_VAL(ALARM_RST_H)) u_ahour (
      .clk(clk), .reset_n(reset_n), .clear(1'b0), .inc(1'b0),
      .up(plus & set_ahour), .dn(minus & set_ahour), .cnt(alarm_hours),
      .carry(unused_alarm_carry[1])
   );

   // The match is judged on the time the current advance is about to produce, so the
   // alarm fires on the same edge that lands on hh:mm:00.
   logic [FIELD_W-1:0] next_mins, next_hours;
   logic               alarm_hit;

   assign next_mins  = min_carry  ? '0 : mins + 6'd1;
   assign next_hours = hour_carry ? '0 : (min_carry ? hours + 6'd1 : hours);
   assign alarm_hit  = alarm_en & sec_carry & (next_mins == alarm_mins)
                     & (next_hours == alarm_hours);

   alarm_state_t      state, state_nx;
   logic [RING_W-1:0] ring_cnt, ring_nx;
   logic [SNZ_W-1:0]  snz_cnt, snz_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         ring_cnt <= '0;
         snz_cnt  <= '0;
      end else begin
         state    <= state_nx;
         ring_cnt <= ring_nx;
         snz_cnt  <= snz_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ring_nx  = ring_cnt;
      snz_nx   = snz_cnt;
      if (!alarm_en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (alarm_hit) begin
                  state_nx = RINGING;
                  ring_nx  = RING_LOAD;
               end
            end
            RINGING: begin
               if (stop) begin
                  state_nx = IDLE;
               end else if (snooze) begin
                  state_nx = SNOOZED;
                  snz_nx   = SNZ_LOAD;
               end else if (tick_1hz) begin
                  if (ring_cnt <= RING_W'(1)) state_nx = IDLE;
                  else                        ring_nx  = ring_cnt - 1'b1;
               end
            end
            SNOOZED: begin
               if (stop) begin
                  state_nx = IDLE;
               end else if (tick_1hz) begin
                  if (snz_cnt <= SNZ_W'(1)) begin
                     state_nx = RINGING;
                     ring_nx  = RING_LOAD;
                  end else begin
                     snz_nx = snz_cnt - 1'b1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign ringing = (state == RINGING);

`ifdef TWELVE_HOUR_EN
   always_comb begin
      disp_hours = hours;
      if (hours == '0)          disp_hours = 6'd12;
      else if (hours > 6'd12)   disp_hours = hours - 6'd12;
   end

   assign pm = (hours >= 6'd12);
`endif

endmodule

// File: tb/tb_clock_alarm.sv
// Scoreboarded bench for clock_alarm: a seconds-of-day reference model predicts every cycle.
module tb_clock_alarm;

   localparam int HZ   = 4;
   localparam int RING = 3;
   localparam int SNZ  = 1;
   localparam int AH   = 7;
   localparam int AM   = 0;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       run = 1'b0, plus = 1'b0, minus = 1'b0;
   logic       alarm_en = 1'b0, snooze = 1'b0, stop = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [5:0] hours, mins, secs, alarm_hours, alarm_mins;
   logic       ringing, tick_1hz;

   clock_alarm #(
      .CLK_HZ(HZ), .RING_SECS(RING), .SNOOZE_MIN(SNZ),
      .ALARM_RST_H(AH), .ALARM_RST_M(AM)
   ) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .plus(plus), .minus(minus),
      .mode(mode), .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
      .hours(hours), .mins(mins), .secs(secs), .alarm_hours(alarm_hours),
      .alarm_mins(alarm_mins), .ringing(ringing), .tick_1hz(tick_1hz)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h, m, s, ah, am;
      bit ring, tick;
   } snap_t;

   snap_t exp_q[$];
   int errors = 0;
   int checks = 0;

   // Reference model: time as seconds of day, alarm state 0=idle 1=ringing 2=snoozed.
   int m_t, m_ah, m_am, m_div, m_st, m_rc, m_sc;
   bit m_last_tick;

   int g_mode = 0;
   bit g_run = 1'b1;
   bit g_en = 1'b0;

   task automatic model_reset();
      m_t = 0; m_ah = AH; m_am = AM; m_div = 0; m_st = 0; m_rc = 0; m_sc = 0;
   endtask

   task automatic model_step(input bit p, input bit mi, input bit sn, input bit sp,
                             input int md, input bit r, input bit en);
      bit tk, adv, hit;
      int d, hh, mm, ss;
      tk  = (m_div == HZ - 1);
      adv = tk && r && !(md >= 1 && md <= 3);
      hit = 1'b0;
      if (adv) begin
         m_t = (m_t + 1) % 86400;
         hit = en && (m_t == (m_ah * 60 + m_am) * 60);
      end
      if (md >= 1 && md <= 5 && p != mi) begin
         d  = p ? 1 : -1;
         hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60;
         case (md)
            1: ss   = (ss + d + 60) % 60;
            2: mm   = (mm + d + 60) % 60;
            3: hh   = (hh + d + 24) % 24;
            4: m_am = (m_am + d + 60) % 60;
            default: m_ah = (m_ah + d + 24) % 24;
         endcase
         m_t = hh * 3600 + mm * 60 + ss;
      end
      m_div = (md == 1 && (p || mi)) ? 0 : (m_div + 1) % HZ;
      if (!en) m_st = 0;
      else begin
         case (m_st)
            0: if (hit) begin m_st = 1; m_rc = RING; end
            1: begin
               if (sp) m_st = 0;
               else if (sn) begin m_st = 2; m_sc = SNZ * 60; end
               else if (tk) begin
                  m_rc = m_rc - 1;
                  if (m_rc == 0) m_st = 0;
               end
            end
            default: begin
               if (sp) m_st = 0;
               else if (tk) begin
                  m_sc = m_sc - 1;
                  if (m_sc == 0) begin m_st = 1; m_rc = RING; end
               end
            end
         endcase
      end
      m_last_tick = tk;
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.h = m_t / 3600; s.m = (m_t / 60) % 60; s.s = m_t % 60;
      s.ah = m_ah; s.am = m_am;
      s.ring = (m_st == 1); s.tick = (m_div == HZ - 1);
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
   task automatic step(input bit p, input bit mi, input bit sn, input bit sp);
      plus = p; minus = mi; snooze = sn; stop = sp;
      mode = 3'(g_mode); run = g_run; alarm_en = g_en;
      model_step(p, mi, sn, sp, g_mode, g_run, g_en);
      exp_q.push_back(model_snap());
      @(negedge clk);
      plus = 1'b0; minus = 1'b0; snooze = 1'b0; stop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_ticks(input int n);
      int got, budget;
      got = 0;
      budget = n * HZ * 2 + HZ;
      while (got < n && budget > 0) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (m_last_tick) got++;
         budget--;
      end
      if (got < n) chk("tick_budget", got, n);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      g_mode = 3;
      for (int k = 0; k < 24 && (m_t / 3600) != h; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
      g_mode = 2;
      for (int k = 0; k < 60 && ((m_t / 60) % 60) != m; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
      g_mode = 1;
      for (int k = 0; k < 60 && (m_t % 60) != s; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
      g_mode = 0;
   endtask

   task automatic set_alarm(input int h, input int m);
      g_mode = 5;
      for (int k = 0; k < 24 && m_ah != h; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
      g_mode = 4;
      for (int k = 0; k < 60 && m_am != m; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      g_mode = 0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_hours"}, hours, 0);
      chk({tag, "_mins"}, mins, 0);
      chk({tag, "_secs"}, secs, 0);
      chk({tag, "_alarm_hours"}, alarm_hours, AH);
      chk({tag, "_alarm_mins"}, alarm_mins, AM);
      chk({tag, "_ringing"}, ringing, 0);
      chk({tag, "_tick"}, tick_1hz, 0);
   endtask

   initial begin : monitor
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (hours !== 6'(e.h) || mins !== 6'(e.m) || secs !== 6'(e.s) ||
                alarm_hours !== 6'(e.ah) || alarm_mins !== 6'(e.am) ||
                ringing !== e.ring || tick_1hz !== e.tick) begin
               errors++;
               $display("FAIL scoreboard at %0t: got %0d:%0d:%0d alarm %0d:%0d ring %0b tick %0b, expected %0d:%0d:%0d alarm %0d:%0d ring %0b tick %0b",
                        $time, hours, mins, secs, alarm_hours, alarm_mins, ringing, tick_1hz,
                        e.h, e.m, e.s, e.ah, e.am, e.ring, e.tick);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin : main
      int s0;
      model_reset();
      #2 reset_n = 1'b0;
      #1 check_reset_values("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      g_run = 1'b1; g_en = 1'b0;

      // 23:59:58 through wrap-around edits, then two seconds to midnight
      g_mode = 3; step(1'b0, 1'b1, 1'b0, 1'b0);
      g_mode = 2; step(1'b0, 1'b1, 1'b0, 1'b0);
      g_mode = 1; step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("preload_hours", hours, 23);
      chk("preload_mins", mins, 59);
      chk("preload_secs", secs, 58);
      g_mode = 0;
      run_ticks(1);
      chk("tick1_secs", secs, 59);
      chk("tick1_mins", mins, 59);
      run_ticks(1);
      chk("midnight_hours", hours, 0);
      chk("midnight_mins", mins, 0);
      chk("midnight_secs", secs, 0);

      // minute edit wraps without carrying; plus+minus cancels
      g_mode = 2;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("min_down_wrap", mins, 59);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("min_up_wrap", mins, 0);
      chk("min_up_no_carry", hours, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("plus_minus_cancel", mins, 0);

      // seconds edit restarts the divider
      g_mode = 1;
      idle(1);
      s0 = m_t % 60;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("sec_edit", secs, (s0 + 1) % 60);
      chk("tick_after_edit", tick_1hz, 0);
      idle(2);
      chk("tick_not_yet", tick_1hz, 0);
      idle(1);
      chk("tick_4_clks", tick_1hz, 1);

      // alarm 00:01 fires from 00:00:59 and times out after RING ticks
      set_alarm(0, 1);
      chk("alarm_hours_set", alarm_hours, 0);
      chk("alarm_mins_set", alarm_mins, 1);
      set_time(0, 0, 59);
      g_en = 1'b1;
      run_ticks(1);
      chk("alarm_fire", ringing, 1);
      chk("alarm_fire_mins", mins, 1);
      chk("alarm_fire_secs", secs, 0);
      run_ticks(2);
      chk("ring_2_ticks", ringing, 1);
      run_ticks(1);
      chk("ring_timeout", ringing, 0);

      // snooze for a minute, then stop beats snooze
      set_time(0, 0, 59);
      run_ticks(1);
      chk("refire", ringing, 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("snoozed", ringing, 0);
      run_ticks(59);
      chk("snooze_59", ringing, 0);
      run_ticks(1);
      chk("snooze_expire", ringing, 1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("stop_over_snooze", ringing, 0);
      run_ticks(4);
      chk("stays_idle", ringing, 0);

      // disarming silences immediately
      set_time(0, 0, 59);
      run_ticks(1);
      chk("fire_before_disarm", ringing, 1);
      g_en = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("disarm", ringing, 0);
      g_en = 1'b1;

      // asynchronous reset mid-ring
      set_time(0, 0, 59);
      run_ticks(1);
      chk("fire_before_reset", ringing, 1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // randomized traffic
      set_alarm(0, 2);
      g_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) g_mode = int'($urandom_range(0, 7));
         else if ($urandom_range(0, 3) == 0) g_mode = 0;
         g_run = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 63) == 0) g_en = !g_en;
         step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 20) == 0, $urandom_range(0, 40) == 0);
      end

      @(posedge clk);
      #3 chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
